// File: rtl/mem_req_ctrl.sv
// Initiator engine between the L1 cache controller and main memory.
// Sequences fill, writeback and evict+fill requests into 256-bit line read/write commands.
module mem_req_ctrl #(
  parameter int unsigned MEM_ENTRIES = 256,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [26:0]  req_addr,
  input  logic [26:0]  req_wb_addr,
  input  logic [255:0] req_wd,
  input  logic [31:0]  req_be,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [255:0] resp_rdata,
  output logic [26:0]  mem_a,
  output logic [31:0]  mem_be,
  output logic [255:0] mem_wd,
  output logic         mem_write,
  output logic         mem_read,
  input  logic [255:0] mem_rd,
  input  logic         mem_valid,
  input  logic         mem_ready
);

  typedef enum logic [2:0] {
    StIdle, StWrSetup, StWrCmd, StWrWait, StRdCmd, StRdWait, StResp
  } state_e;

  localparam logic [26:0]      LineLimit = 27'(MEM_ENTRIES);
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [26:0]    addr_q, addr_d;
  logic           evict_q, evict_d;
  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_err_q, resp_err_d;
  logic [255:0]   resp_rdata_q, resp_rdata_d;
  logic [26:0]    mem_a_q, mem_a_d;
  logic [31:0]    mem_be_q, mem_be_d;
  logic [255:0]   mem_wd_q, mem_wd_d;
  logic           mem_write_q, mem_write_d;
  logic           mem_read_q, mem_read_d;
  logic           bad_req;
  logic           expired;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    evict_d      = evict_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_a_d      = mem_a_q;
    mem_be_d     = mem_be_q;
    mem_wd_d     = mem_wd_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    bad_req      = (req_op == 2'b11)
                || (req_op != 2'b01 && req_addr >= LineLimit)
                || (req_op != 2'b00 && req_wb_addr >= LineLimit);
    // Last wait cycle: the counter would reach TIMEOUT at this edge.
    expired      = (cnt_q == CntLast);

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          evict_d = (req_op == 2'b10);
          if (bad_req) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_op == 2'b00) begin
            state_d    = StRdCmd;
            mem_a_d    = req_addr;
            mem_read_d = 1'b1;
          end else begin
            // Memory latches the address a cycle before the write strobe.
            state_d  = StWrSetup;
            mem_a_d  = req_wb_addr;
            mem_wd_d = req_wd;
            mem_be_d = req_be;
          end
        end
      end
      StWrSetup: begin
        state_d     = StWrCmd;
        mem_write_d = 1'b1;
      end
      StWrCmd: begin
        state_d = StWrWait;
        cnt_d   = '0;
      end
      StWrWait: begin
        if (mem_ready) begin
          if (evict_q) begin
            state_d    = StRdCmd;
            mem_a_d    = addr_q;
            mem_read_d = 1'b1;
          end else begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
          end
        end else if (expired) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdCmd: begin
        state_d = StRdWait;
        cnt_d   = '0;
      end
      StRdWait: begin
        if (mem_valid) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_rd;
        end else if (expired) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      evict_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_a_q      <= '0;
      mem_be_q     <= '0;
      mem_wd_q     <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      evict_q      <= evict_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_a_q      <= mem_a_d;
      mem_be_q     <= mem_be_d;
      mem_wd_q     <= mem_wd_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_be     = mem_be_q;
  assign mem_wd     = mem_wd_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: table of requests against a small main-memory model
// (address registered a cycle ahead of write, 2-cycle read/write response), plus reset/idle cases.
module tb_mem_req_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [26:0]  req_addr;
  logic [26:0]  req_wb_addr;
  logic [255:0] req_wd;
  logic [31:0]  req_be;
  logic         resp_valid;
  logic         resp_err;
  logic [255:0] resp_rdata;
  logic [26:0]  mem_a;
  logic [31:0]  mem_be;
  logic [255:0] mem_wd;
  logic         mem_write;
  logic         mem_read;
  logic [255:0] mem_rd;
  logic         mem_valid;
  logic         mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.MEM_ENTRIES(256), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wb_addr(req_wb_addr), .req_wd(req_wd), .req_be(req_be),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  // Main-memory model
  logic [255:0] mem_array [256];
  logic [26:0]  a_prev    = '0;
  logic         rd_d1     = 1'b0;
  logic         rd_d2     = 1'b0;
  logic         wr_d1     = 1'b0;
  logic         wr_d2     = 1'b0;
  logic         init_done = 1'b0;
  logic [7:0]   rd_line   = '0;
  logic [255:0] mem_rd_r  = '0;
  logic         mute      = 1'b0;
  logic         inj       = 1'b0;
  localparam logic [255:0] InjData = {8{32'hC0FFEE00}};

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem_array[i] <= {32{8'(i)}};
      mem_array[5] <= {32{8'hA5}};
      init_done    <= 1'b1;
    end else if (mem_write) begin
      mem_array[a_prev[7:0]] <= mem_wd;
    end
    a_prev <= mem_a;
    rd_d1  <= mem_read & ~mute;
    rd_d2  <= rd_d1;
    wr_d1  <= mem_write & ~mute;
    wr_d2  <= wr_d1;
    if (mem_read) rd_line <= mem_a[7:0];
    if (rd_d1) mem_rd_r <= mem_array[rd_line];
  end

  assign mem_valid = rd_d2 | inj;
  assign mem_ready = wr_d2 | inj;
  assign mem_rd    = inj ? InjData : mem_rd_r;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe protocol monitor
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_rules",
            {255'd0, (mem_read && mem_write) || (mem_read && prev_rd) || (mem_write && prev_wr)},
            256'd0);
    end
    prev_rd = mem_read;
    prev_wr = mem_write;
  end

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [26:0]  addr;
    logic [26:0]  wb_addr;
    logic [255:0] wd;
    logic [31:0]  be;
    bit           mute;
    int           inj_cyc;
    int           lat;
    bit           err;
    bit           chk_rd;
    logic [255:0] rdata;
    int           n_rd;
    int           n_wr;
  } vec_t;

  function automatic vec_t mk(string name, logic [1:0] op, logic [26:0] addr, logic [26:0] wb,
                              logic [255:0] wd, logic [31:0] be, bit mt, int inj_cyc, int lat,
                              bit err, bit chk_rd, logic [255:0] rdata, int n_rd, int n_wr);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.wb_addr = wb; v.wd = wd; v.be = be;
    v.mute = mt; v.inj_cyc = inj_cyc; v.lat = lat; v.err = err; v.chk_rd = chk_rd;
    v.rdata = rdata; v.n_rd = n_rd; v.n_wr = n_wr;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int budget = 50;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, "_ready_wait"}, {255'd0, req_ready}, 256'd1);
  endtask

  task automatic run_req(input vec_t v);
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   lat    = 0;
    logic err    = 1'b0;
    logic [255:0] rdata = '0;
    logic [26:0]  prev_a = '0;
    logic [26:0]  rd_a = '0;
    logic [26:0]  wr_a = '0;
    logic [26:0]  wr_a_prev = '0;
    logic [31:0]  wr_be = '0;
    @(negedge clk);
    wait_ready(v.name);
    mute        = v.mute;
    req_valid   = 1'b1;
    req_op      = v.op;
    req_addr    = v.addr;
    req_wb_addr = v.wb_addr;
    req_wd      = v.wd;
    req_be      = v.be;
    @(posedge clk);
    #1;
    // Scramble inputs: the engine must have captured them at accept.
    req_valid   = 1'b0;
    req_op      = ~v.op;
    req_addr    = '1;
    req_wb_addr = '1;
    req_wd      = ~v.wd;
    req_be      = ~v.be;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      inj = (c == v.inj_cyc);
      if (mem_read) begin
        rd_cnt++;
        rd_a = mem_a;
      end
      if (mem_write) begin
        wr_cnt++;
        wr_a      = mem_a;
        wr_a_prev = prev_a;
        wr_be     = mem_be;
      end
      if (resp_valid) begin
        lat   = c;
        err   = resp_err;
        rdata = resp_rdata;
      end
      prev_a = mem_a;
    end
    inj  = 1'b0;
    mute = 1'b0;
    check({v.name, "_latency"}, 256'(lat), 256'(v.lat));
    check({v.name, "_err"}, {255'd0, err}, {255'd0, v.err});
    if (v.chk_rd) check({v.name, "_rdata"}, rdata, v.rdata);
    check({v.name, "_reads"}, 256'(rd_cnt), 256'(v.n_rd));
    check({v.name, "_writes"}, 256'(wr_cnt), 256'(v.n_wr));
    if (v.n_rd > 0) check({v.name, "_rd_addr"}, 256'(rd_a), 256'(v.addr));
    if (v.n_wr > 0) begin
      check({v.name, "_wr_addr"}, 256'(wr_a), 256'(v.wb_addr));
      check({v.name, "_wr_setup_addr"}, 256'(wr_a_prev), 256'(v.wb_addr));
      check({v.name, "_wr_be"}, 256'(wr_be), 256'(v.be));
    end
    @(negedge clk);
    check({v.name, "_resp_pulse"}, {255'd0, resp_valid}, 256'd0);
    check({v.name, "_ready_after"}, {255'd0, req_ready}, 256'd1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, {251'd0, req_ready, resp_valid, resp_err, mem_write, mem_read},
          256'd0);
    check({name, "_rdata"}, resp_rdata, 256'd0);
    check({name, "_wd"}, mem_wd, 256'd0);
    check({name, "_a_be"}, {197'd0, mem_a, mem_be}, 256'd0);
  endtask

  localparam logic [255:0] WbData = {16{16'h1234}};
  localparam logic [255:0] EfData = {8{32'hDEADBEEF}};

  vec_t vecs[13];
  int   seen;

  initial begin
    vecs[0]  = mk("fill5",      2'b00, 27'd5,   27'd0,   '0, 32'h0, 1'b0, 0, 4, 1'b0, 1'b1,
                  {32{8'hA5}}, 1, 0);
    vecs[1]  = mk("wb3",        2'b01, 27'd0,   27'd3,   WbData, 32'hFFFF_FFFF, 1'b0, 0, 5,
                  1'b0, 1'b0, '0, 0, 1);
    vecs[2]  = mk("fill3",      2'b00, 27'd3,   27'd0,   '0, 32'h0, 1'b0, 0, 4, 1'b0, 1'b1,
                  WbData, 1, 0);
    vecs[3]  = mk("fill2",      2'b00, 27'd2,   27'd0,   '0, 32'h0, 1'b0, 0, 4, 1'b0, 1'b1,
                  {32{8'h02}}, 1, 0);
    vecs[4]  = mk("evict7fill1", 2'b10, 27'd1,  27'd7,   EfData, 32'h0000_FFFF, 1'b0, 0, 8,
                  1'b0, 1'b1, {32{8'h01}}, 1, 1);
    vecs[5]  = mk("fill7",      2'b00, 27'd7,   27'd0,   '0, 32'h0, 1'b0, 0, 4, 1'b0, 1'b1,
                  EfData, 1, 0);
    vecs[6]  = mk("fill256",    2'b00, 27'd256, 27'd0,   '0, 32'h0, 1'b0, 0, 1, 1'b1, 1'b1,
                  '0, 0, 0);
    vecs[7]  = mk("op11",       2'b11, 27'd0,   27'd0,   '0, 32'h0, 1'b0, 0, 1, 1'b1, 1'b1,
                  '0, 0, 0);
    vecs[8]  = mk("wb300",      2'b01, 27'd0,   27'd300, WbData, 32'hF, 1'b0, 0, 1, 1'b1, 1'b1,
                  '0, 0, 0);
    vecs[9]  = mk("ef_fill256", 2'b10, 27'd256, 27'd4,   WbData, 32'hF, 1'b0, 0, 1, 1'b1, 1'b1,
                  '0, 0, 0);
    vecs[10] = mk("rd_timeout", 2'b00, 27'd4,   27'd0,   '0, 32'h0, 1'b1, 0, 17, 1'b1, 1'b1,
                  '0, 1, 0);
    vecs[11] = mk("wr_timeout", 2'b10, 27'd4,   27'd9,   EfData, 32'hFF00_00FF, 1'b1, 0, 18,
                  1'b1, 1'b1, '0, 0, 1);
    vecs[12] = mk("resp_wins",  2'b00, 27'd8,   27'd0,   '0, 32'h0, 1'b1, 16, 17, 1'b0, 1'b1,
                  InjData, 1, 0);

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wb_addr = '0;
    req_wd = '0; req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {255'd0, req_ready}, 256'd0);
    @(negedge clk);
    check("ready_after_release", {255'd0, req_ready}, 256'd1);

    for (int i = 0; i < 13; i++) run_req(vecs[i]);
    check("line7_written", mem_array[7], EfData);
    check("line2_intact", mem_array[2], {32{8'h02}});

    // Stray responses in IDLE must be ignored.
    inj = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid || mem_read || mem_write || !req_ready) seen++;
    end
    inj = 1'b0;
    check("idle_inject_ignored", 256'(seen), 256'd0);

    // Reset while waiting for read data.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 27'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_read");
    @(negedge clk);
    rst_n = 1'b1;
    inj = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 1) inj = 1'b0;
      if (resp_valid) seen++;
    end
    check("no_resp_after_reset", 256'(seen), 256'd0);
    run_req(mk("fill6_after_rst", 2'b00, 27'd6, 27'd0, '0, 32'h0, 1'b0, 0, 4, 1'b0, 1'b1,
               {32{8'h06}}, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator side of the L1-to-main-memory line interface. It sits between the L1 cache controller and mainmemory.
- Turns cache fill, writeback and evict+fill requests into the 256-bit line read/write command sequences mainmemory requires.
- Waits for mainmemory's valid/ready responses under a timeout, then returns fill data or error status to the cache.

Parameters:
- MEM_ENTRIES, 256, number of 256-bit lines in main memory; any address >= MEM_ENTRIES is rejected.
- TIMEOUT, 15, maximum cycles spent in a wait state before the request is aborted with an error.
- CNT_W, 4, width of the wait counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  cache request present.
- req_ready  out  1  engine can accept; high only in IDLE.
- req_op  in  2  request type: 00 fill, 01 writeback, 10 evict+fill, 11 illegal.
- req_addr  in  27  fill line address.
- req_wb_addr  in  27  victim line address (op 01/10).
- req_wd  in  256  victim line data.
- req_be  in  32  victim byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: illegal op, address range error or timeout.
- resp_rdata  out  256  fill data, valid with resp_valid on op 00/10.
- mem_a  out  27  line address to mainmemory.
- mem_be  out  32  byte enables to mainmemory.
- mem_wd  out  256  write data to mainmemory.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_rd  in  256  read data from mainmemory.
- mem_valid  in  1  read data valid.
- mem_ready  in  1  write complete.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 and the wait counter is 0.
  - req_ready rises in the first cycle after reset is released.
  - A reset mid-operation abandons the transfer; any late mem_valid/mem_ready is ignored.
- All mem_* outputs and resp_* outputs are registered.
- Acceptance:
  - A request is accepted on a posedge where req_valid and req_ready are both 1.
  - req_op, both addresses, req_wd and req_be are captured at that edge.
  - The inputs may change afterwards.
- Illegal and out-of-range requests skip memory entirely and go to RESP with resp_err=1 and resp_rdata=0. This applies to:
  - op 11;
  - req_addr >= MEM_ENTRIES on op 00/10;
  - req_wb_addr >= MEM_ENTRIES on op 01/10.
- States:
  - IDLE: req_ready=1. On accept, go to WR_SETUP for op 01/10, RD_CMD for op 00, or RESP on error.
  - WR_SETUP: mem_a=wb_addr, mem_wd=wd, mem_be=be, mem_write=0. This cycle is mandatory because mainmemory commits wd to the address registered on the previous cycle. Next state is WR_CMD.
  - WR_CMD: mem_write=1 for exactly one cycle, with mem_a, mem_wd and mem_be held. Next state is WR_WAIT.
  - WR_WAIT: mem_write=0, and mem_a/mem_wd stay held. On mem_ready: go to RD_CMD for op 10, or RESP for op 01.
  - RD_CMD: mem_a=fill addr, mem_read=1 for exactly one cycle, mem_write=0. Next state is RD_WAIT.
  - RD_WAIT: mem_read=0. On mem_valid, capture mem_rd into resp_rdata and go to RESP.
  - RESP: resp_valid=1 for one cycle. There is no backpressure. Next state is IDLE.
- resp_err and resp_rdata hold their values until the next RESP.
- Strobes are never asserted on consecutive cycles.
- mem_write and mem_read are never asserted in the same cycle.
- Wait counter:
  - Clears on entry to WR_WAIT and RD_WAIT, and increments each cycle in those states.
  - If the counter reaches TIMEOUT before the response arrives, go to RESP with resp_err=1 and resp_rdata=0.
  - For op 10, a write timeout skips the read.
  - If a response arrives in the same cycle the counter reaches TIMEOUT, the response wins.
- mem_valid/mem_ready outside the matching wait state are ignored.
- Latency (accept cycle = 0, memory READ_LAT=2):
  - fill: resp_valid in cycle 4;
  - writeback: resp_valid in cycle 5;
  - evict+fill: resp_valid in cycle 8;
  - error: resp_valid in cycle 1.
- mem_be is passed through for writes. mainmemory currently ignores it, and the engine must still drive it.

Test Plan:
- Reset, then preload memory line 5 = 256'hA5..A5 and issue fill addr 5 -> mem_read is high in exactly one cycle with mem_a=5; resp_valid in cycle 4, resp_err=0, resp_rdata=A5..A5.
- Writeback with wb_addr=3, wd=256'h1234_..., be=32'hFFFF_FFFF -> mem_a=3 on the cycle before mem_write; mem_write is one cycle wide; resp_valid in cycle 5; a following fill of addr 3 returns 1234_...; line 2 is unchanged.
- Evict+fill with wb_addr=7, fill addr=1 -> write to 7 completes first, then a read of 1; resp_valid in cycle 8 with line 1 data; line 7 holds the written data.
- Requests with req_addr=256, and separately op 11 -> no mem strobe ever; resp_valid with resp_err=1 in cycle 1; req_ready high again in cycle 2.
- Memory stub that never returns mem_valid -> resp_err=1 after TIMEOUT=15 wait cycles and resp_rdata=0; a late mem_valid injected in IDLE is ignored.
- rst_n pulsed low during RD_WAIT -> all outputs are 0 immediately; no resp_valid from the abandoned fill; the next fill completes normally.
